ffo_mask_builder: RTL and testbench
===================================

# ffo_mask_builder

Sequential decoder at the far end of a find-first-one link: accepts a stream of (valid, position) pairs, each as produced by a find-first-one priority encoder scanning a 32-bit word, and rebuilds the original set-bit mask. Beats are accumulated until a beat flagged last. The reconstructed mask, population count and error flags are then held under a valid/ready handshake. It sits downstream of the scanning FFO stage and returns position lists to vector form for the consumer.

## Interface
- N, 32, mask width; bit index 0 is the leftmost/highest-priority bit (vectors declared [0:N-1])
- PW, $clog2(N), position width
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  beat offered
- in_ready  output  1  beat can be accepted; equals !out_valid
- in_v  input  1  encoder valid: position field meaningful
- in_p  input  PW [0:PW-1]  bit position; don't-care (may be X) when in_v=0
- in_last  input  1  final beat of the frame
- out_valid  output  1  frame result held
- out_ready  input  1  consumer takes result
- out_mask  output  N [0:N-1]  reconstructed mask
- out_count  output  PW+1  number of distinct bits set in out_mask
- out_dup  output  1  frame contained a position already set
- out_order_err  output  1  a valid position was not strictly greater than the previous valid position of the frame
- out_range_err  output  1  a valid position was >= N

## Operation
- Two states: ACCUM (out_valid=0, in_ready=1) and HOLD (out_valid=1, in_ready=0).
- Accept: in_valid && in_ready at a rising edge.
- Accepted beat, in_v=1, in_p<N:
  - in_p is compared to last_p, the last valid position of the frame.
  - If a prior valid position exists and in_p <= last_p: set order_err sticky.
  - If mask[in_p] is already 1: set dup sticky; mask and count unchanged.
  - Otherwise: set mask[in_p] and increment count.
  - last_p <= in_p.
- Accepted beat, in_v=1, in_p>=N: set range_err sticky; mask, count and last_p unchanged.
- Accepted beat, in_v=0: no mask, count or flag change. in_p is ignored and X on it must not reach any register. This marks an all-zero word or an empty terminator.
- Accepted beat with in_last=1: the beat is applied, then ACCUM->HOLD.
- The outputs are the accumulator registers themselves, stable throughout HOLD.
- HOLD with out_ready=1:
  - Clear mask, count, flags and the last_p-valid marker.
  - HOLD->ACCUM.
- out_ready is ignored in ACCUM.
- Frames are single-beat minimum; no maximum length. Count saturates at N; it cannot exceed N without duplicates.

## Timing
- Reset (async assert, sync-safe deassert):
  - state ACCUM
  - out_valid=0, in_ready=1
  - out_mask=0, out_count=0, all flags 0
- Beats offered while reset_n is low are discarded.
- Last beat accepted at edge k -> out_valid=1 and final values visible from edge k (same edge updates).
- Output handshake at edge h -> out_valid=0 and all outputs 0 after h. in_ready=1 in the cycle after h.
- No input accept in the same cycle as an output handshake. Throughput is one frame per (beats+1) cycles minimum.
- in_valid held with in_ready=0: the beat waits, is not consumed, and needs no re-presentation order change.
- Reset asserted mid-frame or in HOLD: partial frame and held result are lost; outputs return to reset values immediately.

## Test plan
- Reset: assert reset_n=0 with in_valid=1, in_v=1, in_p=3 -> out_valid=0, in_ready=1, out_mask=0, out_count=0 after release.
- Single bit:
  - Stimulus: beat in_v=1, in_p=0, in_last=1.
  - Response: next cycle out_valid=1, out_mask=32'h8000_0000, out_count=1, flags 0.
  - Then hold out_ready=0 for 3 cycles -> values stable, in_ready=0.
  - Then out_ready=1 -> cleared, and in_ready=1 the next cycle.
- Ordered frame:
  - Stimulus: positions 2, 5, 31 (last on 31), in_valid gapped by idle cycles.
  - Response: out_mask=32'h2400_0001, out_count=3, flags 0.
- Empty and X:
  - Stimulus: single beat in_v=0, in_p=5'bxxxxx, in_last=1.
  - Response: out_mask=0, out_count=0, no X on any output.
- Errors:
  - Stimulus: positions 7, 7, 4 (last).
  - Response: out_mask=32'h0900_0000, out_count=2, out_dup=1, out_order_err=1, out_range_err=0.
  - With N=24: position 30 -> out_range_err=1, mask unchanged.
- Sweep vs model:
  - Stimulus: for i=0..31, frame i carries positions i..31 ascending.
  - Response: out_mask equals ones from bit i to 31, out_count=32-i.
  - Also: assert reset_n mid-frame at i=16 -> the next frame starts from an empty mask.

Source files
------------

// File: rtl/ffo_mask_builder.sv
// Rebuilds a set-bit mask from a stream of find-first-one (valid, position) beats
// and holds the frame result, population count and error flags under valid/ready.
module ffo_mask_builder #(
  parameter int N  = 32,
  parameter int PW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_v,
  input  logic [0:PW-1] in_p,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:N-1]  out_mask,
  output logic [PW:0]   out_count,
  output logic          out_dup,
  output logic          out_order_err,
  output logic          out_range_err
);

  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

  localparam logic [PW:0] N_VAL = (PW+1)'(N);

  state_t        r_state;
  logic [0:N-1]  r_mask;
  logic [PW:0]   r_count;
  logic [0:PW-1] r_last_p;
  logic          r_have_last;
  logic          r_dup;
  logic          r_order_err;
  logic          r_range_err;

  logic          w_accept;
  logic          w_in_range;
  logic          w_pos_ok;
  logic          w_out_of_order;
  logic [0:N-1]  w_hit;
  logic          w_is_dup;
  logic          w_is_new;

  assign w_accept   = in_valid && (r_state == ST_ACCUM);
  // in_v gates everything derived from in_p so an undriven position never leaks into state
  assign w_in_range = in_v && ({1'b0, in_p} < N_VAL);
  assign w_pos_ok   = w_accept && w_in_range;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dec
      assign w_hit[gi] = w_in_range && (in_p == PW'(gi));
    end
  endgenerate

  assign w_is_dup       = |(w_hit & r_mask);
  assign w_is_new       = |(w_hit & ~r_mask);
  assign w_out_of_order = r_have_last && (in_p <= r_last_p);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_ACCUM;
      r_mask      <= '0;
      r_count     <= '0;
      r_last_p    <= '0;
      r_have_last <= 1'b0;
      r_dup       <= 1'b0;
      r_order_err <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_pos_ok) begin
            if (w_out_of_order) r_order_err <= 1'b1;
            if (w_is_dup) r_dup <= 1'b1;
            if (w_is_new) begin
              r_mask <= r_mask | w_hit;
              if (r_count != N_VAL) r_count <= r_count + (PW+1)'(1);
            end
            r_last_p    <= in_p;
            r_have_last <= 1'b1;
          end
          if (w_accept && in_v && !w_in_range) r_range_err <= 1'b1;
          if (w_accept && in_last) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          // result is consumed: clear everything so the next frame starts empty
          if (out_ready) begin
            r_state     <= ST_ACCUM;
            r_mask      <= '0;
            r_count     <= '0;
            r_last_p    <= '0;
            r_have_last <= 1'b0;
            r_dup       <= 1'b0;
            r_order_err <= 1'b0;
            r_range_err <= 1'b0;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign out_valid     = (r_state == ST_HOLD);
  assign in_ready      = !out_valid;
  assign out_mask      = r_mask;
  assign out_count     = r_count;
  assign out_dup       = r_dup;
  assign out_order_err = r_order_err;
  assign out_range_err = r_range_err;

endmodule

// File: tb/tb_ffo_mask_builder.sv
// Scoreboard bench for ffo_mask_builder: frames are modelled when driven and
// checked when the result appears; a second N=24 instance covers range errors.
module tb_ffo_mask_builder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        in_valid, in_ready, in_v, in_last;
  logic [0:4]  in_p;
  logic        out_valid, out_ready;
  logic [0:31] out_mask;
  logic [5:0]  out_count;
  logic        out_dup, out_order_err, out_range_err;

  logic        in_valid24, in_ready24, in_v24, in_last24;
  logic [0:4]  in_p24;
  logic        out_valid24, out_ready24;
  logic [0:23] out_mask24;
  logic [5:0]  out_count24;
  logic        out_dup24, out_order_err24, out_range_err24;

  ffo_mask_builder #(.N(32)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_v(in_v), .in_p(in_p), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_count(out_count),
    .out_dup(out_dup), .out_order_err(out_order_err), .out_range_err(out_range_err)
  );

  ffo_mask_builder #(.N(24)) u_dut24 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid24), .in_ready(in_ready24), .in_v(in_v24), .in_p(in_p24), .in_last(in_last24),
    .out_valid(out_valid24), .out_ready(out_ready24), .out_mask(out_mask24), .out_count(out_count24),
    .out_dup(out_dup24), .out_order_err(out_order_err24), .out_range_err(out_range_err24)
  );

  typedef struct {
    logic [31:0] mask;
    int          count;
    logic        dup;
    logic        ord;
    logic        rng;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t cur;
  bit   seen = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Compare each new frame result against the oldest scoreboard entry
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && out_valid && !seen) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        $display("[TB] frame mask=%h count=%0d dup=%0b ord=%0b rng=%0b",
                 out_mask, out_count, out_dup, out_order_err, out_range_err);
        check_val("sb_mask",  64'(out_mask), 64'(e.mask));
        check_val("sb_count", 64'(out_count), 64'(e.count));
        check_val("sb_flags", 64'({out_dup, out_order_err, out_range_err}),
                  64'({e.dup, e.ord, e.rng}));
      end
    end
    seen = out_valid;
  end

  task automatic beat(input int p, input logic last, input int gap);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    if (!in_ready) check_val("rdy_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_v     = (p >= 0);
    in_p     = (p >= 0) ? p[4:0] : 5'bxxxxx;
    in_last  = last;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_v     = 1'b0;
    in_p     = 5'bxxxxx;
    in_last  = 1'b0;
    if (!last) repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  // Negative position = in_v=0 beat
  task automatic run_frame(input int pos[$], input int gap, input int hold);
    exp_t e;
    int   last_q = 0;
    bit   have   = 1'b0;
    e.mask = '0; e.count = 0; e.dup = 1'b0; e.ord = 1'b0; e.rng = 1'b0;
    foreach (pos[k]) begin
      if (pos[k] >= 0) begin
        if (have && pos[k] <= last_q) e.ord = 1'b1;
        if (e.mask[31 - pos[k]]) e.dup = 1'b1;
        else begin
          e.mask[31 - pos[k]] = 1'b1;
          e.count++;
        end
        last_q = pos[k];
        have   = 1'b1;
      end
    end
    sb_q.push_back(e);
    cur = e;
    foreach (pos[k]) beat(pos[k], (k == pos.size() - 1), gap);
    check_val("last_lat", 64'(out_valid), 64'd1);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(posedge clock); #1;
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_rdy",   64'(in_ready), 64'd0);
      check_val("hold_mask",  64'(out_mask), 64'(cur.mask));
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check_val("clr_valid", 64'(out_valid), 64'd0);
    check_val("clr_rdy",   64'(in_ready), 64'd1);
    check_val("clr_mask",  64'(out_mask), 64'd0);
    check_val("clr_count", 64'(out_count), 64'd0);
    check_val("clr_flags", 64'({out_dup, out_order_err, out_range_err}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    reset_n     = 1'b0;
    in_valid    = 1'b1;
    in_v        = 1'b1;
    in_p        = 5'd3;
    in_last     = 1'b1;
    out_ready   = 1'b0;
    in_valid24  = 1'b0;
    in_v24      = 1'b0;
    in_p24      = 5'd0;
    in_last24   = 1'b0;
    out_ready24 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_v     = 1'b0;
    in_last  = 1'b0;
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_rdy",   64'(in_ready), 64'd1);
    check_val("rst_mask",  64'(out_mask), 64'd0);
    check_val("rst_count", 64'(out_count), 64'd0);
    @(posedge clock); #1;
    check_val("rst_mask2", 64'(out_mask), 64'd0);
    check_val("rst_valid2", 64'(out_valid), 64'd0);

    q = '{0};          run_frame(q, 0, 3);
    q = '{2, 5, 31};   run_frame(q, 2, 0);
    q = '{-1};         run_frame(q, 0, 1);
    q = '{7, 7, 4};    run_frame(q, 1, 0);
    q = '{0, -1, 9};   run_frame(q, 0, 0);

    // Fixed-value checks independent of the model
    in_valid = 1'b1; in_v = 1'b1; in_p = 5'd31; in_last = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0; in_v = 1'b0;
    check_val("lit_mask31", 64'(out_mask), 64'h0000_0001);
    check_val("lit_count31", 64'(out_count), 64'd1);
    sb_q.push_back('{mask: 32'h0000_0001, count: 1, dup: 1'b0, ord: 1'b0, rng: 1'b0});
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;

    // Range error on the narrow instance
    in_valid24 = 1'b1; in_v24 = 1'b1; in_p24 = 5'd3; in_last24 = 1'b0;
    @(posedge clock); #1;
    in_p24 = 5'd30; in_last24 = 1'b1;
    @(posedge clock); #1;
    in_valid24 = 1'b0; in_v24 = 1'b0; in_last24 = 1'b0;
    check_val("n24_valid", 64'(out_valid24), 64'd1);
    check_val("n24_mask",  64'(out_mask24), 64'h10_0000);
    check_val("n24_count", 64'(out_count24), 64'd1);
    check_val("n24_flags", 64'({out_dup24, out_order_err24, out_range_err24}), 64'b001);
    out_ready24 = 1'b1;
    @(posedge clock); #1;
    out_ready24 = 1'b0;
    check_val("n24_clr", 64'({out_valid24, out_range_err24, in_ready24}), 64'b001);

    for (int i = 0; i < 32; i++) begin
      if (i == 16) begin
        for (int p = 16; p <= 20; p++) beat(p, 1'b0, 0);
        reset_n = 1'b0;
        #1;
        check_val("midrst_mask",  64'(out_mask), 64'd0);
        check_val("midrst_count", 64'(out_count), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
      end
      q = {};
      for (int p = i; p < 32; p++) q.push_back(p);
      run_frame(q, 0, 0);
    end
    check_val("sweep_last", 64'(out_count), 64'd0);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
